// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with valid/ready handshakes and a 2-entry skid buffer.
// Define IMM_GEN_CSR_EN to decode CSR*I instructions as fmt Z with a zero-extended zimm.
module imm_gen_pipe #(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int TAG_WIDTH        = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [INSTRUCTION_SIZE-1:0] in_instr,
    input  logic [TAG_WIDTH-1:0]        in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORDSIZE-1:0]         out_imm,
    output logic [2:0]                  out_fmt,
    output logic                        out_illegal,
    output logic [TAG_WIDTH-1:0]        out_tag
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    localparam logic [2:0] FMT_NONE = 3'b000;
    localparam logic [2:0] FMT_I    = 3'b001;
    localparam logic [2:0] FMT_S    = 3'b010;
    localparam logic [2:0] FMT_B    = 3'b011;
    localparam logic [2:0] FMT_U    = 3'b100;
    localparam logic [2:0] FMT_J    = 3'b101;
    localparam logic [2:0] FMT_Z    = 3'b110;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t                state_q, state_d;
    logic                  inReady_q;
    logic                  accept, drain;
    logic                  load0New, load0Skid, load1New;

    logic signed [31:0]    raw32;
    logic                  zimmSel;
    logic [2:0]            decFmt;
    logic                  decIllegal;
    logic [WORDSIZE-1:0]   decImm;

    logic [WORDSIZE-1:0]   imm0_q, imm1_q;
    logic [2:0]            fmt0_q, fmt1_q;
    logic                  ill0_q, ill1_q;
    logic [TAG_WIDTH-1:0]  tag0_q, tag1_q;

    // Immediates are assembled as a signed 32-bit value whose bit 31 is always instr[31],
    // so a single signed widening cast gives the sign extension to WORDSIZE.
    always_comb begin
        raw32      = '0;
        zimmSel    = 1'b0;
        decFmt     = FMT_NONE;
        decIllegal = 1'b0;
        case (in_instr[6:0])
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: begin
                decFmt = FMT_I;
                raw32  = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_SYSTEM: begin
`ifdef IMM_GEN_CSR_EN
                if (in_instr[14]) begin
                    decFmt  = FMT_Z;
                    zimmSel = 1'b1;
                end else begin
                    decFmt = FMT_I;
                    raw32  = {{20{in_instr[31]}}, in_instr[31:20]};
                end
`else
                decFmt = FMT_I;
                raw32  = {{20{in_instr[31]}}, in_instr[31:20]};
`endif
            end
            OP_STORE: begin
                decFmt = FMT_S;
                raw32  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OP_BRANCH: begin
                decFmt = FMT_B;
                raw32  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                          in_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                decFmt = FMT_U;
                raw32  = {in_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                decFmt = FMT_J;
                raw32  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                          in_instr[30:21], 1'b0};
            end
            OP_REG, OP_REG32: decFmt = FMT_NONE;
            default:          decIllegal = 1'b1;
        endcase
        decImm = zimmSel ? WORDSIZE'(in_instr[19:15]) : WORDSIZE'(raw32);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            inReady_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            inReady_q <= (state_d != FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !drain)      state_d = FULL;
                    else if (!accept && drain) state_d = EMPTY;
                end
                FULL:    if (drain) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_ready is masked while reset is held so nothing is offered a transfer mid-reset.
    always_comb begin
        out_valid = (state_q != EMPTY);
        in_ready  = inReady_q && !reset;
        accept    = in_valid && inReady_q;
        drain     = out_valid && out_ready;
        load0Skid = !flush && drain && (state_q == FULL);
        load0New  = !flush && accept && ((state_q == EMPTY) || (state_q == ONE && drain));
        load1New  = !flush && accept && (state_q == ONE) && !drain;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            imm0_q <= '0;
            fmt0_q <= '0;
            ill0_q <= 1'b0;
            tag0_q <= '0;
            imm1_q <= '0;
            fmt1_q <= '0;
            ill1_q <= 1'b0;
            tag1_q <= '0;
        end else begin
            if (load0Skid) begin
                imm0_q <= imm1_q;
                fmt0_q <= fmt1_q;
                ill0_q <= ill1_q;
                tag0_q <= tag1_q;
            end else if (load0New) begin
                imm0_q <= decImm;
                fmt0_q <= decFmt;
                ill0_q <= decIllegal;
                tag0_q <= in_tag;
            end
            if (load1New) begin
                imm1_q <= decImm;
                fmt1_q <= decFmt;
                ill1_q <= decIllegal;
                tag1_q <= in_tag;
            end
        end
    end

    assign out_imm     = imm0_q;
    assign out_fmt     = fmt0_q;
    assign out_illegal = ill0_q;
    assign out_tag     = tag0_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: fixed decode vectors, handshake corner sequences and
// randomized traffic against a queue-based reference model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [63:0] in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic [63:0] out_tag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [63:0] tag;
    } ent_t;

    ent_t modelQ[$];
    vec_t vecs[11];

    imm_gen_pipe #(.WORDSIZE(64), .INSTRUCTION_SIZE(32), .TAG_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Reference decode computed with 64-bit arithmetic shifts straight from the field rules.
    function automatic ent_t refDecode(input logic [31:0] ins, input logic [63:0] tg);
        ent_t e;
        longint s;
        s     = longint'(signed'(ins));
        e.imm = 64'd0;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        e.tag = tg;
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
                e.fmt = 3'd1; e.imm = s >>> 20;
            end
            7'b1110011: begin
`ifdef IMM_GEN_CSR_EN
                if (ins[14]) begin e.fmt = 3'd6; e.imm = longint'(ins[19:15]); end
                else begin e.fmt = 3'd1; e.imm = s >>> 20; end
`else
                e.fmt = 3'd1; e.imm = s >>> 20;
`endif
            end
            7'b0100011: begin
                e.fmt = 3'd2; e.imm = ((s >>> 25) << 5) | longint'(ins[11:7]);
            end
            7'b1100011: begin
                e.fmt = 3'd3;
                e.imm = ((s >>> 31) << 12) | (longint'(ins[7]) << 11) |
                        (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
            end
            7'b0110111, 7'b0010111: begin
                e.fmt = 3'd4; e.imm = (s >>> 12) << 12;
            end
            7'b1101111: begin
                e.fmt = 3'd5;
                e.imm = ((s >>> 31) << 20) | (longint'(ins[19:12]) << 12) |
                        (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
            end
            7'b0110011, 7'b0111011: e.fmt = 3'd0;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check64("in_ready", 64'(in_ready), 64'(!reset && modelQ.size() < 2));
        check64("out_valid", 64'(out_valid), 64'(modelQ.size() > 0));
        if (modelQ.size() > 0) begin
            check64("out_imm", out_imm, modelQ[0].imm);
            check64("out_fmt", 64'(out_fmt), 64'(modelQ[0].fmt));
            check64("out_illegal", 64'(out_illegal), 64'(modelQ[0].ill));
            check64("out_tag", out_tag, modelQ[0].tag);
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then check just after it.
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [63:0] tg,
                                 input logic ordy, input logic fl);
        logic acc, drn;
        in_valid  = v;
        in_instr  = ins;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        acc = v && !reset && (modelQ.size() < 2);
        drn = (modelQ.size() > 0) && ordy;
        @(posedge clk);
        if (reset || fl) begin
            modelQ.delete();
        end else begin
            if (drn) void'(modelQ.pop_front());
            if (acc) modelQ.push_back(refDecode(ins, tg));
        end
        #1;
        checkOutput();
    endtask

    task automatic checkResetOutputs();
        check64("rst_out_valid", 64'(out_valid), 64'd0);
        check64("rst_in_ready", 64'(in_ready), 64'd0);
        check64("rst_out_imm", out_imm, 64'd0);
        check64("rst_out_fmt", 64'(out_fmt), 64'd0);
        check64("rst_out_illegal", 64'(out_illegal), 64'd0);
        check64("rst_out_tag", out_tag, 64'd0);
    endtask

    initial begin
        logic [6:0]  ops[14];
        logic [31:0] r;
        logic [63:0] tagCnt;

        vecs[0]  = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
        vecs[1]  = '{32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
        vecs[2]  = '{32'h123452B7, 64'h0000000012345000, 3'd4, 1'b0};
        vecs[3]  = '{32'hFE000CE3, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0};
        vecs[4]  = '{32'h0000007F, 64'h0000000000000000, 3'd0, 1'b1};
        vecs[5]  = '{32'h00500113, 64'h0000000000000005, 3'd1, 1'b0};
        vecs[6]  = '{32'h00B50533, 64'h0000000000000000, 3'd0, 1'b0};
        vecs[7]  = '{32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0};
        vecs[8]  = '{32'h80000017, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
        vecs[9]  = '{32'h7FF00013, 64'h00000000000007FF, 3'd1, 1'b0};
`ifdef IMM_GEN_CSR_EN
        vecs[10] = '{32'h3002D0F3, 64'h0000000000000005, 3'd6, 1'b0};
`else
        vecs[10] = '{32'h3002D0F3, 64'h0000000000000300, 3'd1, 1'b0};
`endif

        ops = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0111011,
                7'b1111111, 7'b0000000};
        tagCnt = 64'h1000;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs();
        reset = 1'b0;
        #1;
        check64("ready_after_reset", 64'(in_ready), 64'd1);

        // Table vectors streamed back to back with out_ready high.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, vecs[i].instr, tagCnt + 64'(i), 1'b1, 1'b0);
            check64("tbl_imm", out_imm, vecs[i].imm);
            check64("tbl_fmt", 64'(out_fmt), 64'(vecs[i].fmt));
            check64("tbl_illegal", 64'(out_illegal), 64'(vecs[i].ill));
            check64("tbl_tag", out_tag, tagCnt + 64'(i));
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

        // Backpressure: three offers against a stalled consumer, then release.
        applyStimulus(1'b1, 32'h00100093, 64'hA1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00200093, 64'hA2, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00300093, 64'hA3, 1'b0, 1'b0);
        check64("bp_full_ready", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, 32'h00300093, 64'hA3, 1'b0, 1'b0);
        check64("bp_hold_tag", out_tag, 64'hA1);
        applyStimulus(1'b1, 32'h00300093, 64'hA3, 1'b1, 1'b0);
        check64("bp_second_tag", out_tag, 64'hA2);
        applyStimulus(1'b1, 32'h00300093, 64'hA3, 1'b1, 1'b0);
        check64("bp_third_tag", out_tag, 64'hA3);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        check64("bp_drained", 64'(out_valid), 64'd0);

        // Flush while FULL with an instruction offered in the same cycle.
        applyStimulus(1'b1, 32'h00400093, 64'hB1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00500093, 64'hB2, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00600093, 64'hB3, 1'b0, 1'b1);
        check64("flush_valid", 64'(out_valid), 64'd0);
        check64("flush_ready", 64'(in_ready), 64'd1);
        repeat (2) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

        // Reset while FULL.
        applyStimulus(1'b1, 32'h00700093, 64'hC1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00800093, 64'hC2, 1'b0, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b1, 32'h00900093, 64'hC3, 1'b0, 1'b0);
        checkResetOutputs();
        reset = 1'b0;
        #1;
        check64("ready_after_midreset", 64'(in_ready), 64'd1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            applyStimulus(1'($urandom_range(0, 3) != 0),
                          {r[31:7], ops[$urandom_range(0, 13)]},
                          {$urandom(), $urandom()},
                          1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 40) == 0));
        end
        repeat (3) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
